// File: rtl/axis_to_dac_interface.sv
// AXIS 64-bit words -> FIFO -> 32-bit DAC samples, upper half first. Output is registered and runs 1 clock behind RUN.
// tready drops when the FIFO is full. Optional macro AXIS_DAC_TLAST_SYNC_EN aligns playback to frame starts via tlast.
module axis_to_dac_interface #(
  parameter int DATA_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 16,
  parameter int PREFILL_LEVEL = 4
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH/2-1:0]       o_dac_data,
  output logic                          o_dac_valid,
  input  logic                          i_con_axisside,
  input  logic                          i_con_dacside,
  output logic                          o_status,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = DATA_WIDTH / 2;
`ifdef AXIS_DAC_TLAST_SYNC_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif
  localparam logic [AW:0] LP_DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LP_PREFILL = (AW+1)'(PREFILL_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_RUN,
    ST_UNDERRUN
  } state_t;

  logic [FW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            w_full;
  logic            w_empty;
  logic            w_wr;
  logic            w_rd;
  logic [FW-1:0]   w_wr_word;
  logic [FW-1:0]   w_head;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_phase;
  logic            w_phase_nxt;
  logic [SW-1:0]   r_hold;
  logic [SW-1:0]   w_hold_nxt;
  logic [SW-1:0]   r_dac_data;
  logic [SW-1:0]   w_data_nxt;
  logic            r_dac_valid;
  logic            w_valid_nxt;
  logic            r_status;
  logic            w_status_nxt;
  logic            w_prefill_ok;

`ifdef AXIS_DAC_TLAST_SYNC_EN
  logic            r_synced;
  logic            w_synced_nxt;
  assign w_wr_word    = {s_axis_tlast, s_axis_tdata};
  assign w_prefill_ok = r_synced && (r_level >= LP_PREFILL);
`else
  logic            w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
  assign w_wr_word      = s_axis_tdata;
  assign w_prefill_ok   = (r_level >= LP_PREFILL);
`endif

  assign w_full        = (r_level == LP_DEPTH);
  assign w_empty       = (r_level == '0);
  // Gated by reset so tready is low while held in reset regardless of i_con_axisside.
  assign s_axis_tready = s_axis_aresetn & i_con_axisside & ~w_full;
  assign w_wr          = s_axis_tvalid & s_axis_tready;
  assign w_head        = r_mem[r_rd_ptr];

  assign o_dac_data    = r_dac_data;
  assign o_dac_valid   = r_dac_valid;
  assign o_status      = r_status;
  assign o_fifo_level  = r_level;

  always_ff @(posedge s_axis_aclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wr_word;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state     <= ST_IDLE;
      r_phase     <= 1'b0;
      r_hold      <= '0;
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
      r_status    <= 1'b0;
`ifdef AXIS_DAC_TLAST_SYNC_EN
      r_synced    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_hold      <= w_hold_nxt;
      r_dac_data  <= w_data_nxt;
      r_dac_valid <= w_valid_nxt;
      r_status    <= w_status_nxt;
`ifdef AXIS_DAC_TLAST_SYNC_EN
      r_synced    <= w_synced_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_hold_nxt   = r_hold;
    w_data_nxt   = '0;
    w_valid_nxt  = 1'b0;
    w_status_nxt = r_status;
    w_rd         = 1'b0;
`ifdef AXIS_DAC_TLAST_SYNC_EN
    w_synced_nxt = r_synced;
`endif
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt  = 1'b0;
        w_status_nxt = 1'b0;
        if (i_con_dacside) w_state_nxt = ST_PREFILL;
`ifdef AXIS_DAC_TLAST_SYNC_EN
        w_synced_nxt = 1'b0;
`endif
      end
      ST_PREFILL: begin
`ifdef AXIS_DAC_TLAST_SYNC_EN
        // Discard up to and including the next frame end so playback starts on a frame's first word.
        if (!r_synced && !w_empty) begin
          w_rd = 1'b1;
          if (w_head[DATA_WIDTH]) w_synced_nxt = 1'b1;
        end
`endif
        if (!i_con_dacside)    w_state_nxt = ST_IDLE;
        else if (w_prefill_ok) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!r_phase) begin
          if (!w_empty) begin
            w_rd        = 1'b1;
            w_data_nxt  = w_head[DATA_WIDTH-1:SW];
            w_hold_nxt  = w_head[SW-1:0];
            w_valid_nxt = 1'b1;
            w_phase_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_UNDERRUN;
            w_status_nxt = 1'b1;
          end
        end else begin
          w_data_nxt  = r_hold;
          w_valid_nxt = 1'b1;
          w_phase_nxt = 1'b0;
          if (!i_con_dacside) w_state_nxt = ST_IDLE;
        end
      end
      ST_UNDERRUN: begin
        w_state_nxt = ST_PREFILL;
`ifdef AXIS_DAC_TLAST_SYNC_EN
        w_synced_nxt = 1'b0;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_IDLE) w_status_nxt = 1'b0;
  end

endmodule

// File: tb/tb_axis_to_dac_interface.sv
// Bench for axis_to_dac_interface: directed scenarios plus random traffic against a word-queue scoreboard.
module tb_axis_to_dac_interface;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic        tready;
  logic [31:0] dac_data;
  logic        dac_valid;
  logic        axisside;
  logic        dacside;
  logic        status;
  logic [4:0]  level;

  always #5 clk = ~clk;

  axis_to_dac_interface #(.DATA_WIDTH(64), .FIFO_DEPTH(DEPTH), .PREFILL_LEVEL(4)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tvalid  (tvalid),
    .s_axis_tdata   (tdata),
    .s_axis_tlast   (tlast),
    .s_axis_tready  (tready),
    .o_dac_data     (dac_data),
    .o_dac_valid    (dac_valid),
    .i_con_axisside (axisside),
    .i_con_dacside  (dacside),
    .o_status       (status),
    .o_fifo_level   (level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: accepted words in order; each word must come out as upper then lower on consecutive clocks.
  logic [63:0] q[$];
  int          mdl_level;
  bit          exp_lower;
  logic [31:0] exp_low_val;
  int          cyc, n_smp, first_cyc, last_cyc;

  task automatic clear_model();
    q.delete();
    mdl_level = 0;
    exp_lower = 0;
    n_smp     = 0;
  endtask

  task automatic step();
    bit          hs;
    bit          popped;
    logic [63:0] w;
    #1;
    hs = tvalid && axisside && (mdl_level != DEPTH);
    chk("tready", tready, axisside && (mdl_level != DEPTH));
    if (hs) q.push_back(tdata);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    popped = 0;
    if (exp_lower) begin
      chk("lower_valid", dac_valid, 1'b1);
      chk("lower_data", dac_data, exp_low_val);
      exp_lower = 0;
    end else if (dac_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", dac_valid, 1'b0);
      end else begin
        w = q.pop_front();
        chk("upper_data", dac_data, w[63:32]);
        exp_low_val = w[31:0];
        exp_lower   = 1;
        popped      = 1;
      end
    end
    mdl_level = mdl_level + int'(hs) - int'(popped);
    chk("level", level, mdl_level);
    if (dac_valid) begin
      if (n_smp == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_smp++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tvalid = 1'b0;
    dacside = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    axisside = 1'b1;
    dacside  = 1'b0;
    tvalid   = 1'b0;
    tdata    = '0;
    tlast    = 1'b0;
    cyc      = 0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_tready", tready, 1'b0);
    chk("rst_valid", dac_valid, 1'b0);
    chk("rst_data", dac_data, 32'h0);
    chk("rst_status", status, 1'b0);
    chk("rst_level", level, 5'd0);
    rst_n = 1'b1;

    // Four known words, then playback until underrun.
    for (int i = 1; i <= 4; i++) begin
      tvalid = 1'b1;
      tdata  = {16'hAAAA, 16'(i), 16'hBBBB, 16'(i)};
      step();
    end
    tvalid  = 1'b0;
    n_smp   = 0;
    dacside = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 2)  chk("t1_no_early_sample", dac_valid, 1'b0);
      if (k == 3)  chk("t1_first_sample", dac_data, 32'hAAAA0001);
      if (k == 10) chk("t1_status_low", status, 1'b0);
    end
    chk("t1_nsamples", n_smp, 8);
    chk("t1_gapless", last_cyc - first_cyc + 1, 8);
    chk("t1_underrun_valid", dac_valid, 1'b0);
    chk("t1_underrun_status", status, 1'b1);

    // Resume at half rate, then stop while an upper half is on the bus.
    for (int k = 0; k < 40; k++) begin
      tvalid = (k % 2 == 0);
      tdata  = {$urandom, $urandom};
      step();
    end
    tvalid = 1'b0;
    for (int b = 0; b < 4 && !exp_lower; b++) step();
    chk("t4_upper_on_bus", exp_lower, 1'b1);
    chk("t4_sticky", status, 1'b1);
    dacside = 1'b0;
    step();
    chk("t4_status_cleared", status, 1'b0);
    step();
    chk("t4_idle_valid", dac_valid, 1'b0);
    chk("t4_idle_data", dac_data, 32'h0);
    repeat (3) step();

    // Fill to full with the DAC side stopped, then drain.
    do_reset();
    axisside = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tvalid = 1'b1;
      tdata  = {$urandom, $urandom};
      step();
    end
    chk("t2_level_full", level, 5'd16);
    chk("t2_accepted", q.size(), 16);
    #1 chk("t2_tready_full", tready, 1'b0);
    tvalid  = 1'b0;
    n_smp   = 0;
    dacside = 1'b1;
    repeat (40) step();
    chk("t2_drained", q.size(), 0);
    chk("t2_nsamples", n_smp, 32);
    chk("t2_gapless", last_cyc - first_cyc + 1, 32);

    // Sustained one word per two clocks gives gapless output.
    do_reset();
    axisside = 1'b1;
    dacside  = 1'b1;
    n_smp    = 0;
    for (int k = 0; k < 430; k++) begin
      tvalid = (k % 2 == 0);
      tdata  = {$urandom, $urandom};
      step();
    end
    chk("t3_enough", n_smp >= 200, 1'b1);
    chk("t3_gapless", last_cyc - first_cyc + 1, n_smp);
    chk("t3_status", status, 1'b0);

    // Asynchronous reset in the middle of a running stream.
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", dac_valid, 1'b0);
    chk("t5_data", dac_data, 32'h0);
    chk("t5_tready", tready, 1'b0);
    chk("t5_level", level, 5'd0);
    chk("t5_status", status, 1'b0);
    @(negedge clk);
    clear_model();
    tvalid  = 1'b0;
    dacside = 1'b0;
    rst_n   = 1'b1;

    // Random traffic and control toggles.
    for (int k = 0; k < 1500; k++) begin
      tvalid = ($urandom_range(0, 9) < 6);
      tdata  = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) dacside = ~dacside;
      if ($urandom_range(0, 29) == 0) axisside = ~axisside;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
